// File: rtl/startup_sequencer.sv
// Power-on sequencer: after a filtered PLL lock, releases NUM_STAGES ready bits in order,
// each after its own delay. Define STARTUP_RELOCK_EN to rerun the sequence on lock loss in DONE.
module startup_sequencer #(
   parameter int unsigned                         NUM_STAGES  = 3,
   parameter int unsigned                         DELAY_WIDTH = 32,
   parameter logic [NUM_STAGES*DELAY_WIDTH-1:0]   STAGE_DELAY = {32'd1000, 32'd100000, 32'd5040000},
   parameter int unsigned                         LOCK_FILTER = 16
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 locked,
   output logic [NUM_STAGES-1:0]                ready,
   output logic                                 all_ready,
   output logic [$clog2(NUM_STAGES+1)-1:0]      stage,
   output logic                                 restart_pulse
);

   localparam int unsigned SW = $clog2(NUM_STAGES + 1);
   localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

   typedef enum logic [1:0] {StWaitLock, StFilter, StSeq, StDone} state_e;

   state_e                  state_q, state_d;
   logic [FW-1:0]           filt_q, filt_d;
   logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
   logic [SW-1:0]           stage_q, stage_d;
   logic [NUM_STAGES-1:0]   ready_q, ready_d;
   logic                    restart_q, restart_d;

   // A zero delay field still costs one cycle.
   logic [DELAY_WIDTH-1:0]  eff_delay [NUM_STAGES];
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_delay
      assign eff_delay[k] = (STAGE_DELAY[k*DELAY_WIDTH +: DELAY_WIDTH] == '0) ?
                            DELAY_WIDTH'(1) : STAGE_DELAY[k*DELAY_WIDTH +: DELAY_WIDTH];
   end

   logic [DELAY_WIDTH-1:0]  cur_delay;
   logic [NUM_STAGES-1:0]   cur_bit;
   always_comb begin
      cur_delay = eff_delay[0];
      cur_bit   = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         if (stage_q == SW'(k)) begin
            cur_delay  = eff_delay[k];
            cur_bit[k] = 1'b1;
         end
      end
   end

   // Compare at DELAY_WIDTH+1 bits so an all-ones delay field is reachable without wrap.
   logic [DELAY_WIDTH:0]    cnt_plus;
   logic [DELAY_WIDTH-1:0]  cnt_sat;
   logic                    release_now;
   logic                    last_stage;
   assign cnt_plus    = {1'b0, cnt_q} + (DELAY_WIDTH+1)'(1);
   assign cnt_sat     = cnt_plus[DELAY_WIDTH] ? cnt_q : cnt_plus[DELAY_WIDTH-1:0];
   assign release_now = (cnt_plus == {1'b0, cur_delay});
   assign last_stage  = (stage_q == SW'(NUM_STAGES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StWaitLock;
         filt_q    <= '0;
         cnt_q     <= '0;
         stage_q   <= '0;
         ready_q   <= '0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         filt_q    <= filt_d;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         ready_q   <= ready_d;
         restart_q <= restart_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      filt_d    = filt_q;
      cnt_d     = cnt_q;
      stage_d   = stage_q;
      ready_d   = ready_q;
      restart_d = 1'b0;
      unique case (state_q)
         StWaitLock: begin
            filt_d = '0;
            if (locked) begin
               state_d = StFilter;
               filt_d  = FW'(1);
            end
         end
         StFilter: begin
            if (!locked) begin
               state_d = StWaitLock;
               filt_d  = '0;
            end else if (filt_q >= FW'(LOCK_FILTER)) begin
               state_d = StSeq;
               filt_d  = '0;
               cnt_d   = '0;
               stage_d = '0;
            end else begin
               filt_d = filt_q + FW'(1);
            end
         end
         StSeq: begin
            if (!locked) begin
               // Lock loss beats a same-edge stage release.
               state_d   = StWaitLock;
               filt_d    = '0;
               cnt_d     = '0;
               stage_d   = '0;
               ready_d   = '0;
               restart_d = 1'b1;
            end else if (release_now) begin
               ready_d = ready_q | cur_bit;
               stage_d = stage_q + SW'(1);
               cnt_d   = '0;
               if (last_stage) begin
                  state_d = StDone;
               end
            end else begin
               cnt_d = cnt_sat;
            end
         end
         StDone: begin
`ifdef STARTUP_RELOCK_EN
            if (!locked) begin
               state_d   = StWaitLock;
               filt_d    = '0;
               cnt_d     = '0;
               stage_d   = '0;
               ready_d   = '0;
               restart_d = 1'b1;
            end
`else
            state_d = StDone;
`endif
         end
         default: state_d = StWaitLock;
      endcase
   end

   always_comb begin
      ready         = ready_q;
      all_ready     = ready_q[NUM_STAGES-1];
      stage         = stage_q;
      restart_pulse = restart_q;
   end

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer: two instances (stage-0 delay 2 and 0), LOCK_FILTER=4.
module tb_startup_sequencer;

   localparam logic [95:0] SD_A = {32'd5, 32'd3, 32'd2};
   localparam logic [95:0] SD_B = {32'd5, 32'd3, 32'd0};

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       locked = 1'b0;
   logic [2:0] ready_a, ready_b;
   logic       all_ready_a, all_ready_b;
   logic [1:0] stage_a, stage_b;
   logic       restart_a, restart_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clock = ~clock;

   startup_sequencer #(
      .NUM_STAGES (3),
      .DELAY_WIDTH(32),
      .STAGE_DELAY(SD_A),
      .LOCK_FILTER(4)
   ) u_dut_a (
      .clock        (clock),
      .reset        (reset),
      .locked       (locked),
      .ready        (ready_a),
      .all_ready    (all_ready_a),
      .stage        (stage_a),
      .restart_pulse(restart_a)
   );

   startup_sequencer #(
      .NUM_STAGES (3),
      .DELAY_WIDTH(32),
      .STAGE_DELAY(SD_B),
      .LOCK_FILTER(4)
   ) u_dut_b (
      .clock        (clock),
      .reset        (reset),
      .locked       (locked),
      .ready        (ready_b),
      .all_ready    (all_ready_b),
      .stage        (stage_b),
      .restart_pulse(restart_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_a(input string tag, input logic [2:0] rdy, input logic [1:0] stg,
                          input logic rst_p);
      check_eq({tag, ".ready"}, 32'(ready_a), 32'(rdy));
      check_eq({tag, ".all_ready"}, 32'(all_ready_a), 32'(rdy[2]));
      check_eq({tag, ".stage"}, 32'(stage_a), 32'(stg));
      check_eq({tag, ".restart"}, 32'(restart_a), 32'(rst_p));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   // Leaves reset released between edges; the next edge is cycle 1.
   task automatic do_reset();
      locked = 1'b0;
      reset  = 1'b0;
      tick();
      tick();
      check_a("in_reset", 3'b000, 2'd0, 1'b0);
      reset = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      // Normal sequence: lock sampled from cycle 10.
      do_reset();
      run_to(9);
      locked = 1'b1;
      run_to(14);
      check_a("seq_c14", 3'b000, 2'd0, 1'b0);
      check_eq("b_c14.ready", 32'(ready_b), 32'd0);
      run_to(15);
      check_a("seq_c15", 3'b000, 2'd0, 1'b0);
      check_eq("b_zero_delay_c15.ready", 32'(ready_b), 32'd1);
      check_eq("b_zero_delay_c15.stage", 32'(stage_b), 32'd1);
      run_to(16);
      check_a("seq_c16", 3'b001, 2'd1, 1'b0);
      run_to(18);
      check_a("seq_c18", 3'b001, 2'd1, 1'b0);
      run_to(19);
      check_a("seq_c19", 3'b011, 2'd2, 1'b0);
      run_to(23);
      check_a("seq_c23", 3'b011, 2'd2, 1'b0);
      run_to(24);
      check_a("seq_c24", 3'b111, 2'd3, 1'b0);

      // Lock loss in DONE.
      run_to(25);
      locked = 1'b0;
      run_to(26);
`ifdef STARTUP_RELOCK_EN
      check_a("done_drop_c26", 3'b000, 2'd0, 1'b1);
      run_to(27);
      check_a("done_drop_c27", 3'b000, 2'd0, 1'b0);
      run_to(29);
      locked = 1'b1;
      run_to(35);
      check_a("relock_c35", 3'b000, 2'd0, 1'b0);
      run_to(36);
      check_a("relock_c36", 3'b001, 2'd1, 1'b0);
`else
      check_a("done_hold_c26", 3'b111, 2'd3, 1'b0);
      run_to(30);
      check_a("done_hold_c30", 3'b111, 2'd3, 1'b0);
`endif

      // Short lock glitch, then real lock from cycle 20.
      do_reset();
      run_to(4);
      locked = 1'b1;
      run_to(7);
      locked = 1'b0;
      run_to(8);
      check_a("glitch_c8", 3'b000, 2'd0, 1'b0);
      run_to(19);
      check_a("glitch_c19", 3'b000, 2'd0, 1'b0);
      locked = 1'b1;
      run_to(25);
      check_a("glitch_c25", 3'b000, 2'd0, 1'b0);
      run_to(26);
      check_a("glitch_c26", 3'b001, 2'd1, 1'b0);

      // Lock lost on the edge where ready[1] would rise.
      do_reset();
      run_to(9);
      locked = 1'b1;
      run_to(18);
      check_a("abort_c18", 3'b001, 2'd1, 1'b0);
      locked = 1'b0;
      run_to(19);
      check_a("abort_c19", 3'b000, 2'd0, 1'b1);
      run_to(20);
      check_a("abort_c20", 3'b000, 2'd0, 1'b0);
      locked = 1'b1;
      run_to(26);
      check_a("abort_relock_c26", 3'b000, 2'd0, 1'b0);
      run_to(27);
      check_a("abort_relock_c27", 3'b001, 2'd1, 1'b0);

      // Asynchronous reset mid-sequence, then restart.
      do_reset();
      run_to(9);
      locked = 1'b1;
      run_to(17);
      check_a("async_pre", 3'b001, 2'd1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_a("async_in", 3'b000, 2'd0, 1'b0);
      check_eq("async_in_b.ready", 32'(ready_b), 32'd0);
      #1;
      reset = 1'b1;
      cyc   = 0;
      run_to(6);
      check_a("async_post_c6", 3'b000, 2'd0, 1'b0);
      run_to(7);
      check_a("async_post_c7", 3'b001, 2'd1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
